// File: rtl/mem_bridge.sv
// CPU memory-port bridge: registers a request, decodes it to RAM or MMIO and runs a valid/ready bus cycle.
// Optional MEM_BRIDGE_STATS_EN adds done/error counters. Latency: done 2+k cycles after the request, faults after 1.
module mem_bridge #(
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter logic [31:0] RAM_SIZE  = 32'h0001_0000,
    parameter logic [31:0] MMIO_BASE = 32'h1100_0000,
    parameter logic [31:0] MMIO_SIZE = 32'h0000_1000,
    parameter int          TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [3:0]  cpu_be,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_error,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [1:0]  mem_sel,
    input  logic [31:0] mem_rdata
`ifdef MEM_BRIDGE_STATS_EN
    ,
    output logic [31:0] txn_count,
    output logic [15:0] err_count
`endif
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_q, wdata_q;
    logic [3:0]    be_q;
    logic          we_q;
    logic [1:0]    sel_q;
    logic          req, in_ram, in_mmio, fault;
    logic [1:0]    sel_d;

    assign req = cpu_rd | cpu_wr;

    always_comb begin
        in_ram  = (cpu_addr & ~(RAM_SIZE - 32'd1)) == RAM_BASE;
        in_mmio = (cpu_addr & ~(MMIO_SIZE - 32'd1)) == MMIO_BASE;
        // RAM wins when the regions overlap
        sel_d   = in_ram ? 2'b01 : (in_mmio ? 2'b10 : 2'b00);
        fault   = (cpu_rd & cpu_wr) | (cpu_be == 4'h0) | (cpu_addr[1:0] != 2'b00)
                | !(in_ram | in_mmio);
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (req) state_d = fault ? ERR : REQ;
            REQ: begin
                if (mem_ready)       state_d = RESP;
                else if (cnt == TMAX) state_d = ERR;
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_valid = (state == REQ);
        mem_sel   = (state == REQ) ? sel_q : 2'b00;
        cpu_done  = (state == RESP) || (state == ERR);
        cpu_error = (state == ERR);
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = wdata_q;
        mem_we    = we_q;
        mem_be    = be_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            cpu_rdata <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && req) begin
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                be_q    <= cpu_be;
                we_q    <= cpu_wr;
                sel_q   <= sel_d;
            end
            if (state == REQ) begin
                if (mem_ready) begin
                    cnt <= '0;
                    if (!we_q) cpu_rdata <= mem_rdata;
                end else if (cnt == TMAX) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

`ifdef MEM_BRIDGE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_count <= '0;
            err_count <= '0;
        end else begin
            if (cpu_done) txn_count <= txn_count + 32'd1;
            // saturate so a long error storm never looks like a clean run
            if (cpu_error && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_bridge.sv
// Bench for mem_bridge: vector table with a scoreboard of expected completions, plus timeout and reset sequences.
module tb_mem_bridge;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_rd, cpu_wr, cpu_done, cpu_error;
    logic [3:0]  cpu_be;
    logic        mem_valid, mem_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [1:0]  mem_sel;
`ifdef MEM_BRIDGE_STATS_EN
    logic [31:0] txn_count;
    logic [15:0] err_count;
`endif

    always #5 clk = ~clk;

    mem_bridge #(
        .RAM_BASE(32'h0000_0000), .RAM_SIZE(32'h0001_0000),
        .MMIO_BASE(32'h1100_0000), .MMIO_SIZE(32'h0000_1000),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_error(cpu_error),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_be(mem_be), .mem_sel(mem_sel),
        .mem_rdata(mem_rdata)
`ifdef MEM_BRIDGE_STATS_EN
        , .txn_count(txn_count), .err_count(err_count)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        int          waits;   // slave wait cycles; >= TIMEOUT means never ready
        logic [31:0] sdata;
        logic [1:0]  sel;     // expected mem_sel, 0 = decode fault
        logic        err;     // expected cpu_error
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nvalid;
    } exp_t;

    vec_t        vecs[12];
    exp_t        sb[$];
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] model_rdata;
    int          exp_txn, exp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        exp_t e, got;
        int   n, nv;
        bit   done;
        e.err = v.err;
        if (v.sel == 2'b00) begin
            e.lat = 1; e.nvalid = 0;
        end else if (v.err) begin
            e.lat = TIMEOUT + 1; e.nvalid = TIMEOUT;
        end else begin
            e.lat = v.waits + 2; e.nvalid = v.waits + 1;
        end
        if (!v.err && v.rd && !v.wr) model_rdata = v.sdata;
        e.rdata = model_rdata;
        sb.push_back(e);

        cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_rd = v.rd; cpu_wr = v.wr; cpu_be = v.be;
        mem_ready = 1'b0;
        n = 0; nv = 0; done = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (cpu_done) begin
                got = sb.pop_front();
                check("latency", n, got.lat);
                check("valid_cycles", nv, got.nvalid);
                check("cpu_error", cpu_error, got.err);
                check("cpu_rdata", cpu_rdata, got.rdata);
                exp_txn++;
                if (got.err) exp_err++;
                cpu_rd = 1'b0; cpu_wr = 1'b0; mem_ready = 1'b0;
                done = 1;
            end else if (mem_valid) begin
                check("mem_sel", mem_sel, v.sel);
                check("mem_we", mem_we, v.wr);
                check("mem_addr", mem_addr, v.addr);
                check("mem_be", mem_be, v.be);
                if (v.wr) check("mem_wdata", mem_wdata, v.wdata);
                mem_ready = (nv == v.waits);
                mem_rdata = (nv == v.waits) ? v.sdata : $urandom;
                nv++;
            end else begin
                check("mem_sel_idle", mem_sel, 2'b00);
                mem_ready = 1'b0;
            end
        end
        if (!done) begin
            checks++; fails++;
            $display("FAIL txn_budget: no cpu_done after %0d cycles, addr %h", n, v.addr);
            void'(sb.pop_front());
            cpu_rd = 1'b0; cpu_wr = 1'b0; mem_ready = 1'b0;
        end
        @(posedge clk); #1;
        check("done_pulse", cpu_done, 1'b0);
        check("valid_after", mem_valid, 1'b0);
    endtask

    initial begin
        //          addr          wdata         rd wr be    waits sdata         sel    err
        vecs[0]  = '{32'h0000_0100, 32'h0,        1, 0, 4'hF, 2,   32'hDEAD_BEEF, 2'b01, 0};
        vecs[1]  = '{32'h1100_0010, 32'h5A,       0, 1, 4'h1, 0,   32'hBAD0_BAD0, 2'b10, 0};
        vecs[2]  = '{32'h2000_0000, 32'h0,        1, 0, 4'hF, 0,   32'h0,         2'b00, 1};
        vecs[3]  = '{32'h0000_0102, 32'h0,        1, 0, 4'hF, 0,   32'h0,         2'b00, 1};
        vecs[4]  = '{32'h0000_0200, 32'h1,        1, 1, 4'hF, 0,   32'h0,         2'b00, 1};
        vecs[5]  = '{32'h0000_0204, 32'h0,        1, 0, 4'h0, 0,   32'h0,         2'b00, 1};
        vecs[6]  = '{32'h0000_FFFC, 32'hA1B2C3D4, 0, 1, 4'h3, 1,   32'h7777_7777, 2'b01, 0};
        vecs[7]  = '{32'h0000_FFFC, 32'h0,        1, 0, 4'hF, 0,   32'h1234_5678, 2'b01, 0};
        vecs[8]  = '{32'h1100_0FFC, 32'h0,        1, 0, 4'hC, 3,   32'hA5A5_5A5A, 2'b10, 0};
        vecs[9]  = '{32'h0001_0000, 32'h0,        1, 0, 4'hF, 0,   32'h0,         2'b00, 1};
        vecs[10] = '{32'h0000_0040, 32'h0,        1, 0, 4'hF, 99,  32'h0,         2'b01, 1};
        vecs[11] = '{32'h0000_0044, 32'h0,        1, 0, 4'hF, 0,   32'hCAFE_F00D, 2'b01, 0};

        rst = 1'b1;
        cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_be = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        model_rdata = '0; exp_txn = 0; exp_err = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_done", cpu_done, 1'b0);
        check("rst_error", cpu_error, 1'b0);
        check("rst_valid", mem_valid, 1'b0);
        check("rst_sel", mem_sel, 2'b00);
        check("rst_addr", mem_addr, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_txn(vecs[i]);

        // reset while the bus cycle is still waiting for ready
        cpu_addr = 32'h0000_0200; cpu_rd = 1'b1; cpu_be = 4'hF; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_valid", mem_valid, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", mem_valid, 1'b0);
        check("mid_rst_done", cpu_done, 1'b0);
        check("mid_rst_error", cpu_error, 1'b0);
        check("mid_rst_rdata", cpu_rdata, 32'h0);
        cpu_rd = 1'b0;
        rst = 1'b0;
        model_rdata = '0; exp_txn = 0; exp_err = 0;
        @(posedge clk); #1;
        check("post_rst_done", cpu_done, 1'b0);

        // three good accesses and one fault after reset
        run_txn(vecs[0]);
        run_txn(vecs[1]);
        run_txn(vecs[2]);
        run_txn(vecs[7]);
`ifdef MEM_BRIDGE_STATS_EN
        check("txn_count", txn_count, exp_txn);
        check("err_count", {16'h0, err_count}, exp_err);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Memory-side bridge directly downstream of the multicycle CPU's single memory port.
- Registers each CPU read/write request and decodes it to RAM or MMIO.
- Drives a valid/ready memory bus, waiting for the slave's ready.
- Returns read data with a one-cycle done pulse, and drives the CPU's error input on bad or timed-out accesses.

Parameters:
RAM_BASE, 32'h0000_0000, RAM region base (aligned to RAM_SIZE)
RAM_SIZE, 32'h0001_0000, RAM region bytes (power of 2)
MMIO_BASE, 32'h1100_0000, MMIO region base (aligned to MMIO_SIZE)
MMIO_SIZE, 32'h0000_1000, MMIO region bytes (power of 2)
TIMEOUT, 16, max cycles mem_valid may wait for mem_ready (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
cpu_addr  in  32  byte address from CPU
cpu_wdata  in  32  write data from CPU
cpu_rd  in  1  read request (level)
cpu_wr  in  1  write request (level)
cpu_be  in  4  byte-lane enables
cpu_rdata  out  32  registered read data
cpu_done  out  1  one-cycle completion pulse
cpu_error  out  1  one-cycle error pulse, coincident with cpu_done; feeds the CPU error input
mem_valid  out  1  bus request valid
mem_ready  in  1  slave accepts/completes
mem_addr  out  32  word-aligned bus address
mem_wdata  out  32  bus write data
mem_we  out  1  1=write, 0=read
mem_be  out  4  bus byte enables
mem_sel  out  2  one-hot slave select: [0]=RAM, [1]=MMIO
mem_rdata  in  32  slave read data, valid with mem_ready on reads

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- FSM states: IDLE, REQ, RESP, ERR.
- IDLE:
  - If cpu_rd|cpu_wr is high, latch addr/wdata/be/we into registers.
  - Fault if any of: cpu_rd&cpu_wr; cpu_be==0; cpu_addr[1:0]!=0; address outside both regions. Fault -> ERR.
  - Otherwise -> REQ.
- REQ:
  - Drive mem_valid=1 with the latched mem_addr/mem_wdata/mem_we/mem_be/mem_sel; all held stable until handshake.
  - On mem_ready: reads capture mem_rdata into cpu_rdata; -> RESP; clear counter.
  - Counter increments each REQ cycle without mem_ready.
  - After TIMEOUT non-ready cycles, -> ERR with mem_valid dropped; a ready arriving in that same cycle wins over the timeout.
- RESP: cpu_done=1 for one cycle -> IDLE.
- ERR: cpu_done=1 and cpu_error=1 for one cycle -> IDLE. Erroring reads leave cpu_rdata unchanged.
- Latency:
  - Request seen at edge T.
  - mem_valid high at T+1.
  - Ready after k wait cycles (at T+1+k) gives cpu_done at T+2+k.
  - Fault gives cpu_done/cpu_error at T+1.
- cpu_rdata holds its value until the next successful read; writes never alter it.
- Outside REQ: mem_valid=0, mem_sel=0. Address/data outputs may hold stale values.
- CPU must drop cpu_rd/cpu_wr in the cycle after done. A request still high in IDLE is treated as new.
- Region decode: addr & ~(SIZE-1) == BASE. RAM is checked first if regions overlap.
- Reset mid-transaction: the in-flight access is abandoned, mem_valid is 0 from the next cycle, and no done or error is produced.

Optional Feature:
- Macro MEM_BRIDGE_STATS_EN.
- Defined:
  - Adds outputs txn_count[31:0] and err_count[15:0], both reset to 0.
  - txn_count increments on every cpu_done, wrapping at 2^32.
  - err_count increments on every cpu_error, saturating at 16'hFFFF.
- Undefined: the ports and counters do not exist.

Test Plan:
- RAM read: addr 0x0000_0100, be 4'hF, slave ready after 2 waits with data 0xDEADBEEF -> mem_sel 2'b01, mem_we 0, cpu_done at T+4, cpu_rdata 0xDEADBEEF.
- MMIO write: addr 0x1100_0010, wdata 0x5A, be 4'h1, ready immediately -> mem_we 1, mem_sel 2'b10, mem_be 4'h1, done at T+2, cpu_rdata unchanged.
- Unmapped read 0x2000_0000 and misaligned 0x0000_0102 -> no mem_valid; done+error at T+1.
- Timeout: read to RAM, mem_ready never asserted, TIMEOUT=16 -> mem_valid high exactly 16 cycles, then done+error, then IDLE.
- Reset asserted while in REQ -> next cycle: mem_valid 0, cpu_done 0, cpu_rdata 0; a new read then completes normally.
- With MEM_BRIDGE_STATS_EN: 3 good accesses + 1 fault -> txn_count 4, err_count 1.
